// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the hazard controller: register address, shadow slot and FSM state.
package hazard_ctrl_pkg;

  localparam int HAZ_REG_AW = 5;
  localparam int HAZ_LAT_W  = 4;

  typedef logic Signal;
  typedef logic [HAZ_REG_AW-1:0] RegAddr;

  typedef struct packed {
    Signal  valid;
    RegAddr rd;
    Signal  reg_write;
    Signal  mem_read;
  } HazSlot;

  typedef enum logic {
    RUN   = 1'b0,
    MBUSY = 1'b1
  } HazState;

  // A slot "hits" an address when it will write that register; $0 never matches.
  function automatic Signal slot_hit(input HazSlot s, input RegAddr a);
    return s.valid & s.reg_write & (s.rd == a) & (a != '0);
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Forwarding select for one source operand, checked against the X and M shadow slots.
module fwd_unit
  import hazard_ctrl_pkg::*;
(
  input  RegAddr src_a,
  input  Signal  src_used,
  input  HazSlot sx,
  input  HazSlot sm,
  output Signal  hit_x,
  output Signal  fwd_x,
  output Signal  fwd_m
);

  // X wins over M; a load in X has no result yet, so it is never forwarded from X.
  always_comb begin
    hit_x = src_used & slot_hit(sx, src_a);
    fwd_x = hit_x & ~sx.mem_read;
    fwd_m = src_used & slot_hit(sm, src_a) & ~fwd_x;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard detection and sequencing for the 5-stage core: forwarding selects,
// load-use and multi-cycle stalls, and fetch/decode squash on taken branches.
// Slot address width follows the package; REG_AW must match HAZ_REG_AW.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = HAZ_REG_AW,
  parameter int LAT_W  = HAZ_LAT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_valid,
  input  logic [REG_AW-1:0] d_rs_a,
  input  logic              d_rs_used,
  input  logic [REG_AW-1:0] d_rt_a,
  input  logic              d_rt_used,
  input  logic [REG_AW-1:0] d_rd_a,
  input  logic              d_reg_write,
  input  logic              d_mem_read,
  input  logic              d_multi,
  input  logic [LAT_W-1:0]  d_multi_lat,
  input  logic              x_branch_taken,
  output logic              fwdX_rs,
  output logic              fwdX_rt,
  output logic              fwdM_rs,
  output logic              fwdM_rt,
  output logic              stall,
  output logic              flush_fd
);

  HazState            state;
  logic [LAT_W-1:0]   cnt;
  HazSlot             sx;
  HazSlot             sm;
  HazSlot             d_slot;
  logic               post_rst;
  logic               active;
  logic               branch;
  logic               load_use;
  logic               start_multi;
  logic               rs_hit_x;
  logic               rt_hit_x;
  logic               rs_fwd_x;
  logic               rs_fwd_m;
  logic               rt_fwd_x;
  logic               rt_fwd_m;

  fwd_unit u_fwd_rs (
    .src_a    (d_rs_a),
    .src_used (d_rs_used),
    .sx       (sx),
    .sm       (sm),
    .hit_x    (rs_hit_x),
    .fwd_x    (rs_fwd_x),
    .fwd_m    (rs_fwd_m)
  );

  fwd_unit u_fwd_rt (
    .src_a    (d_rt_a),
    .src_used (d_rt_used),
    .sx       (sx),
    .sm       (sm),
    .hit_x    (rt_hit_x),
    .fwd_x    (rt_fwd_x),
    .fwd_m    (rt_fwd_m)
  );

  // Decide stall/flush and gate every output off during reset and the cycle after it.
  always_comb begin
    active      = ~rst & ~post_rst;
    branch      = active & x_branch_taken & (state == RUN);
    load_use    = d_valid & sx.mem_read & (rs_hit_x | rt_hit_x);
    flush_fd    = branch;
    stall       = active & ((state == MBUSY) | (load_use & ~branch));
    fwdX_rs     = active & rs_fwd_x;
    fwdX_rt     = active & rt_fwd_x;
    fwdM_rs     = active & rs_fwd_m;
    fwdM_rt     = active & rt_fwd_m;
    d_slot           = '0;
    d_slot.valid     = d_valid & ~flush_fd;
    d_slot.rd        = d_rd_a;
    d_slot.reg_write = d_reg_write;
    d_slot.mem_read  = d_mem_read;
    start_multi = d_slot.valid & d_multi & (d_multi_lat != '0);
  end

  // Advance the shadow slots and run the multi-cycle busy countdown.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      cnt      <= '0;
      sx       <= '0;
      sm       <= '0;
      post_rst <= 1'b1;
    end else begin
      post_rst <= 1'b0;
      case (state)
        RUN: begin
          sm <= sx;
          if (stall) begin
            sx <= '0;
          end else begin
            sx <= d_slot;
            if (start_multi) begin
              state <= MBUSY;
              cnt   <= d_multi_lat;
            end
          end
        end
        MBUSY: begin
          cnt <= cnt - LAT_W'(1);
          if (cnt == LAT_W'(1)) begin
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
